// File: rtl/filter_frame_ctrl.sv
// Frame sequencer for the filter pipeline: pixel handshake, row/col tracking, window/output valid, drain and frame_done.
// Optional FRAME_AUTO_RESTART_EN: DONE re-enters FILL/RUN directly so frames run back-to-back without start.
module filter_frame_ctrl #(
    parameter int WIDTH_IMG  = 300,
    parameter int HEIGHT_IMG = 300,
    parameter int KERNEL     = 3,
    parameter int PIPE_LAT   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic start,
    input  logic pix_valid_in,
    output logic pix_ready_out,
    output logic lb_wr_en,
    output logic [((WIDTH_IMG > 1) ? $clog2(WIDTH_IMG) : 1)-1:0]   col,
    output logic [((HEIGHT_IMG > 1) ? $clog2(HEIGHT_IMG) : 1)-1:0] row,
    output logic win_valid,
    output logic out_valid,
    output logic busy,
    output logic frame_done
);
    localparam int CW = (WIDTH_IMG > 1) ? $clog2(WIDTH_IMG) : 1;
    localparam int RW = (HEIGHT_IMG > 1) ? $clog2(HEIGHT_IMG) : 1;
    localparam int DW = $clog2(PIPE_LAT + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    // With a 1x1 kernel there are no priming lines, so a frame starts directly in RUN.
    localparam logic [2:0] S_FIRST = (KERNEL == 1) ? S_RUN : S_FILL;

    logic [2:0]          state, state_nxt;
    logic [DW-1:0]       drain_cnt;
    logic [PIPE_LAT-1:0] valid_sr;
    logic                accept, col_last, last_pixel, in_window;

    assign pix_ready_out = enable && (state == S_FILL || state == S_RUN);
    assign accept        = pix_valid_in && pix_ready_out;
    assign lb_wr_en      = accept;
    assign col_last      = int'(col) == WIDTH_IMG - 1;
    assign last_pixel    = col_last && int'(row) == HEIGHT_IMG - 1;
    assign in_window     = int'(row) >= KERNEL - 1 && int'(col) >= KERNEL - 1;
    assign busy          = state != S_IDLE;
    // Gated by enable so a frozen DONE state still yields one pulse per frame.
    assign frame_done    = enable && state == S_DONE;
    assign out_valid     = valid_sr[PIPE_LAT-1];

    always_comb begin
        // NOTE: default assignment first, so no branch leaves state_nxt unassigned and no latch is inferred.
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_FIRST;
            S_FILL:  if (accept && col_last && int'(row) == KERNEL - 2) state_nxt = S_RUN;
            S_RUN:   if (accept && last_pixel) state_nxt = S_DRAIN;
            S_DRAIN: if (drain_cnt == '0) state_nxt = S_DONE;
`ifdef FRAME_AUTO_RESTART_EN
            S_DONE:  state_nxt = S_FIRST;
`else
            S_DONE:  state_nxt = S_IDLE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: every register uses non-blocking (<=) so all updates at an edge see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            col       <= '0;
            row       <= '0;
            win_valid <= 1'b0;
            drain_cnt <= '0;
        end else if (enable) begin
            state     <= state_nxt;
            win_valid <= accept && in_window;
            if (state == S_IDLE && start) begin
                col <= '0;
                row <= '0;
            end else if (accept) begin
                if (last_pixel) begin
                    // Counters are left cleared so an auto-restarted frame begins at (0,0).
                    col       <= '0;
                    row       <= '0;
                    drain_cnt <= DW'(PIPE_LAT);
                end else if (col_last) begin
                    col <= '0;
                    row <= row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
            if (state == S_DRAIN && drain_cnt != '0)
                drain_cnt <= drain_cnt - DW'(1);
        end
    end

    // Kernel latency model: win_valid delayed PIPE_LAT enabled cycles.
    generate
        if (PIPE_LAT == 1) begin : g_sr1
            always_ff @(posedge clk) begin
                if (rst)         valid_sr <= '0;
                else if (enable) valid_sr <= win_valid;
            end
        end else begin : g_srn
            always_ff @(posedge clk) begin
                if (rst)         valid_sr <= '0;
                else if (enable) valid_sr <= {valid_sr[PIPE_LAT-2:0], win_valid};
            end
        end
    endgenerate
endmodule

// File: tb/tb_filter_frame_ctrl.sv
// Self-checking bench for filter_frame_ctrl: per-cycle comparison against a tick-history reference model,
// plus per-scenario frame totals and timing derived from the frame rules.
module tb_filter_frame_ctrl;
    localparam int W    = 5;
    localparam int H    = 4;
    localparam int K    = 3;
    localparam int P    = 2;
    localparam int NPIX = W * H;
    localparam int NWIN = (W - K + 1) * (H - K + 1);
    localparam int HMAX = 8192;

    logic       clk = 1'b0;
    logic       rst = 1'b1, enable = 1'b0, start = 1'b0, pix_valid_in = 1'b0;
    logic       pix_ready_out, lb_wr_en, win_valid, out_valid, busy, frame_done;
    logic [2:0] col;
    logic [1:0] row;

    filter_frame_ctrl #(.WIDTH_IMG(W), .HEIGHT_IMG(H), .KERNEL(K), .PIPE_LAT(P)) dut (
        .clk(clk), .rst(rst), .enable(enable), .start(start), .pix_valid_in(pix_valid_in),
        .pix_ready_out(pix_ready_out), .lb_wr_en(lb_wr_en), .col(col), .row(row),
        .win_valid(win_valid), .out_valid(out_valid), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_fail = 0, cyc = 0;
    // Reference model: a frame is "pixel index k of NPIX"; tick counts enabled (or reset) edges;
    // hist[t] records whether the edge at tick t launched a legal window.
    int tick = 0, hist_floor = 0, m_k = 0, done_tick = -1;
    bit m_busy = 1'b0, m_known = 1'b0;
    bit hist [HMAX];
    int seen_acc, seen_win, seen_out, seen_done, last_done_cyc, last_acc_cyc;

    function automatic bit hget(input int i);
        if (i < 0 || i < hist_floor || i >= HMAX) return 1'b0;
        return hist[i];
    endfunction

    task automatic clear_counts();
        seen_acc = 0; seen_win = 0; seen_out = 0; seen_done = 0; last_done_cyc = -1; last_acc_cyc = -1;
    endtask

    task automatic run_cycle(input logic r, input logic en, input logic st, input logic pv);
        bit exp_ready, exp_acc, exp_win, exp_out, exp_done, exp_busy;
        logic [2:0] exp_col;
        logic [1:0] exp_row;
        rst = r; enable = en; start = st; pix_valid_in = pv;
        @(negedge clk);
        exp_ready = en && m_busy && (m_k < NPIX);
        exp_acc   = exp_ready && pv;
        exp_win   = hget(tick - 1);
        exp_out   = hget(tick - 1 - P);
        exp_done  = en && m_busy && (tick == done_tick);
        exp_busy  = m_busy;
        exp_col   = 3'(m_k % W);
        exp_row   = 2'(m_k / W);
        if (m_known) begin
            n_checks += 6;
            if (pix_ready_out !== exp_ready) begin n_fail++; $display("FAIL ready cyc=%0d got=%b exp=%b", cyc, pix_ready_out, exp_ready); end
            if (lb_wr_en !== exp_acc)        begin n_fail++; $display("FAIL lb_wr_en cyc=%0d got=%b exp=%b", cyc, lb_wr_en, exp_acc); end
            if (win_valid !== exp_win)       begin n_fail++; $display("FAIL win_valid cyc=%0d got=%b exp=%b", cyc, win_valid, exp_win); end
            if (out_valid !== exp_out)       begin n_fail++; $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_out); end
            if (busy !== exp_busy)           begin n_fail++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy); end
            if (frame_done !== exp_done)     begin n_fail++; $display("FAIL frame_done cyc=%0d got=%b exp=%b", cyc, frame_done, exp_done); end
            if (m_busy && m_k < NPIX) begin
                n_checks += 2;
                if (col !== exp_col) begin n_fail++; $display("FAIL col cyc=%0d got=%0d exp=%0d", cyc, col, exp_col); end
                if (row !== exp_row) begin n_fail++; $display("FAIL row cyc=%0d got=%0d exp=%0d", cyc, row, exp_row); end
            end
        end
        if (lb_wr_en === 1'b1) begin seen_acc++; last_acc_cyc = cyc; end
        if (en && win_valid === 1'b1) seen_win++;
        if (en && out_valid === 1'b1) seen_out++;
        if (frame_done === 1'b1) begin seen_done++; last_done_cyc = cyc; end
        @(posedge clk);
        if (r) begin
            m_busy = 1'b0; m_k = 0; done_tick = -1; m_known = 1'b1;
            hist_floor = tick + 1;
            tick++;
        end else if (en) begin
            if (tick < HMAX) hist[tick] = exp_acc && (m_k / W >= K - 1) && (m_k % W >= K - 1);
            if (exp_done) begin
`ifdef FRAME_AUTO_RESTART_EN
                m_k = 0;
`else
                m_busy = 1'b0;
`endif
                done_tick = -1;
            end else if (!m_busy && st) begin
                m_busy = 1'b1; m_k = 0;
            end
            if (exp_acc) begin
                m_k++;
                if (m_k == NPIX) done_tick = tick + P + 2;
            end
            tick++;
        end
        #1;
        cyc++;
    endtask

    // mode: 0 continuous, 1 enable stall at (3,2), 2 source bubbles, 3 start held while busy, 4 random
    task automatic run_frame(input int mode, output int done_rel);
        int c0, stall_left, post;
        bit stalled, en, st, pv;
        clear_counts();
        c0 = cyc; stall_left = 0; stalled = 1'b0; post = 0; done_rel = -1;
        run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 400; i++) begin
            en = 1'b1; pv = 1'b1; st = 1'b0;
            case (mode)
                1: begin
                    if (!stalled && m_busy && m_k == 2 * W + 3) begin stall_left = 3; stalled = 1'b1; end
                    if (stall_left > 0) begin en = 1'b0; stall_left--; end
                end
                2: pv = (i % 2 == 0);
                3: st = (seen_done == 0);
                4: begin en = ($urandom_range(0, 3) != 0); pv = ($urandom_range(0, 2) != 0); end
                default: ;
            endcase
            run_cycle(1'b0, en, st, pv);
            if (seen_done > 0) post++;
            if (post >= 3) break;
        end
        n_checks++;
        if (seen_done == 0) begin
            n_fail++; $display("FAIL frame_timeout mode=%0d got=no frame_done exp=frame_done within 400 cycles", mode);
        end else begin
            done_rel = last_done_cyc - c0;
        end
    endtask

    task automatic check_totals(input string name, input int done_rel, input int exp_rel);
        n_checks += 5;
        if (seen_acc != NPIX)  begin n_fail++; $display("FAIL %s accepts got=%0d exp=%0d", name, seen_acc, NPIX); end
        if (seen_win != NWIN)  begin n_fail++; $display("FAIL %s win_valid got=%0d exp=%0d", name, seen_win, NWIN); end
        if (seen_out != NWIN)  begin n_fail++; $display("FAIL %s out_valid got=%0d exp=%0d", name, seen_out, NWIN); end
        if (seen_done != 1)    begin n_fail++; $display("FAIL %s frame_done_count got=%0d exp=1", name, seen_done); end
        if (exp_rel >= 0 && done_rel != exp_rel) begin
            n_fail++; $display("FAIL %s frame_done_cycle got=%0d exp=%0d", name, done_rel, exp_rel);
        end
    endtask

    task automatic test_reset();
        run_cycle(1'b1, 1'b0, 1'b0, 1'b1);
        run_cycle(1'b1, 1'b1, 1'b1, 1'b1);   // start and rst together: rst wins
        run_cycle(1'b0, 1'b1, 1'b0, 1'b1);
        n_checks += 4;
        if (busy !== 1'b0)         begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (col !== 3'd0)          begin n_fail++; $display("FAIL reset_col got=%0d exp=0", col); end
        if (row !== 2'd0)          begin n_fail++; $display("FAIL reset_row got=%0d exp=0", row); end
        if (pix_ready_out !== 1'b0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0", pix_ready_out); end
    endtask

    task automatic test_basic();
        int rel;
        run_frame(0, rel);
        check_totals("basic", rel, NPIX + P + 2);
    endtask

    task automatic test_enable_stall();
        int rel;
        run_frame(1, rel);
        check_totals("stall", rel, NPIX + P + 2 + 3);
    endtask

    task automatic test_bubbles();
        int rel;
        run_frame(2, rel);
        check_totals("bubbles", rel, 2 * NPIX - 1 + P + 2);
    endtask

    task automatic test_start_busy();
        int rel;
        run_frame(3, rel);
        check_totals("start_busy", rel, NPIX + P + 2);
    endtask

    task automatic test_random();
        int rel;
        for (int f = 0; f < 3; f++) begin
            run_frame(4, rel);
            check_totals("random", rel, -1);
        end
    endtask

    task automatic test_reset_mid();
        int rel, budget;
        clear_counts();
        run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        budget = 0;
        while (!(m_busy && m_k == 2 * W + 1) && budget < 100) begin
            run_cycle(1'b0, 1'b1, 1'b0, 1'b1);
            budget++;
        end
        run_cycle(1'b1, 1'b1, 1'b0, 1'b1);
        n_checks += 4;
        if (busy !== 1'b0)      begin n_fail++; $display("FAIL midreset_busy got=%b exp=0", busy); end
        if (col !== 3'd0)       begin n_fail++; $display("FAIL midreset_col got=%0d exp=0", col); end
        if (row !== 2'd0)       begin n_fail++; $display("FAIL midreset_row got=%0d exp=0", row); end
        if (win_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_win got=%b exp=0", win_valid); end
        for (int i = 0; i < 8; i++) run_cycle(1'b0, 1'b1, 1'b0, 1'b1);
        n_checks++;
        if (seen_done != 0) begin n_fail++; $display("FAIL midreset_no_done got=%0d exp=0", seen_done); end
        run_frame(0, rel);
        check_totals("after_reset", rel, NPIX + P + 2);
    endtask

`ifdef FRAME_AUTO_RESTART_EN
    task automatic test_auto_restart();
        int d1, d2, first2;
        clear_counts();
        d1 = -1; d2 = -1; first2 = -1;
        run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 200 && d2 < 0; i++) begin
            run_cycle(1'b0, 1'b1, 1'b0, 1'b1);
            if (seen_done == 1 && d1 < 0) d1 = last_done_cyc;
            if (seen_done == 2 && d2 < 0) d2 = last_done_cyc;
            if (seen_acc == NPIX + 1 && first2 < 0) first2 = last_acc_cyc;
        end
        run_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        n_checks += 3;
        if (d2 - d1 != NPIX + P + 2) begin n_fail++; $display("FAIL auto_spacing got=%0d exp=%0d", d2 - d1, NPIX + P + 2); end
        if (first2 != d1 + 1)        begin n_fail++; $display("FAIL auto_first_accept got=%0d exp=%0d", first2, d1 + 1); end
        if (busy !== 1'b1)           begin n_fail++; $display("FAIL auto_busy got=%b exp=1", busy); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef FRAME_AUTO_RESTART_EN
        test_auto_restart();
`else
        test_basic();
        test_enable_stall();
        test_bubbles();
        test_reset_mid();
        test_start_busy();
        test_random();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
